// File: rtl/pattern_gen_param_if.sv
// Output stream bundle of the pattern generator: data word, valid, start-of-frame, ready.
// Pure wiring, no latency of its own.
// Master drives o_DATA/o_VALID/o_SOF and holds them while i_READY is low.
interface pattern_gen_param_if #(
  parameter int DW = 16
);
  logic [DW-1:0] o_DATA;
  logic          o_VALID;
  logic          o_SOF;
  logic          i_READY;

  modport master (output o_DATA, output o_VALID, output o_SOF, input i_READY);
  modport slave  (input  o_DATA, input  o_VALID, input  o_SOF, output i_READY);
endinterface

// File: rtl/pattern_gen_param.sv
// Free-running framed test-pattern source: RAM table, counter, walking-one or PRBS7 words.
// Latency: first word one cycle after i_EN is seen in IDLE; then one word per accepted cycle.
// Backpressure: while o_VALID && !i_READY the output word, valid and SOF hold unchanged.
// Optional feature macro: PATTERN_ERR_INJ_EN adds i_INJ (invert bit 0 of the next loaded word).
module pattern_gen_param #(
  parameter int DW = 16,
  parameter int AW = 2,
  parameter int LW = 8
) (
  input  logic          i_CLK,
  input  logic          i_RST_N,
  input  logic          i_EN,
  input  logic [1:0]    i_MODE,
  input  logic [LW-1:0] i_LEN,
  input  logic          i_WR_EN,
  input  logic [AW-1:0] i_WR_ADDR,
  input  logic [DW-1:0] i_WR_DATA,
`ifdef PATTERN_ERR_INJ_EN
  input  logic          i_INJ,
`endif
  pattern_gen_param_if.master o_stream
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_sof;
  logic [LW-1:0] r_idx;
  logic [LW-1:0] r_len_q;
  logic [1:0]    r_mode_q;
  logic [6:0]    r_prbs;

  logic          w_accept;
  logic          w_load;
  logic          w_frame_start;
  logic [LW-1:0] w_idx_nxt;
  logic [1:0]    w_mode_sel;
  logic [6:0]    w_seed;
  logic [6:0]    w_prbs_nxt;
  logic [DW-1:0] w_prbs_word;
  logic [DW-1:0] w_word;
  logic [DW-1:0] w_word_out;

`ifdef PATTERN_ERR_INJ_EN
  logic          r_inj;
  logic          w_inj;
`endif

  // FSM state register
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and load decision; a frame starts on entry from IDLE or after the last index
  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_frame_start = 1'b0;
    w_accept      = r_valid && o_stream.i_READY;
    case (r_state)
      S_IDLE: begin
        if (i_EN) begin
          w_state_nxt   = S_RUN;
          w_load        = 1'b1;
          w_frame_start = 1'b1;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (i_EN) begin
            w_load        = 1'b1;
            w_frame_start = (r_idx == r_len_q);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Word generation for the index being loaded; mode/len come straight from inputs at frame start
  always_comb begin
    w_idx_nxt   = w_frame_start ? '0 : r_idx + 1'b1;
    w_mode_sel  = w_frame_start ? i_MODE : r_mode_q;
    w_seed      = w_frame_start ? 7'h7F : r_prbs;
    w_prbs_nxt  = w_seed;
    w_prbs_word = '0;
    for (int b = 0; b < DW; b++) begin
      w_prbs_word[b] = w_prbs_nxt[6] ^ w_prbs_nxt[5];
      w_prbs_nxt     = {w_prbs_nxt[5:0], w_prbs_word[b]};
    end
    case (w_mode_sel)
      2'b00:   w_word = r_mem[w_idx_nxt[AW-1:0]];
      2'b01:   w_word = DW'(w_idx_nxt);
      2'b10:   w_word = DW'(1) << (32'(w_idx_nxt) % DW);
      default: w_word = w_prbs_word;
    endcase
`ifdef PATTERN_ERR_INJ_EN
    // A request arriving in the load cycle itself still hits this word
    w_inj      = r_inj | i_INJ;
    w_word_out = w_word ^ {{(DW-1){1'b0}}, w_inj};
`else
    w_word_out = w_word;
`endif
  end

  // Output word, handshake flags and generator state
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_sof    <= 1'b0;
      r_idx    <= '0;
      r_len_q  <= '0;
      r_mode_q <= 2'b00;
      r_prbs   <= 7'h7F;
    end else if (w_load) begin
      r_data  <= w_word_out;
      r_valid <= 1'b1;
      r_sof   <= w_frame_start;
      r_idx   <= w_idx_nxt;
      r_prbs  <= w_prbs_nxt;
      if (w_frame_start) begin
        r_mode_q <= i_MODE;
        r_len_q  <= i_LEN;
      end
    end else if (w_state_nxt == S_IDLE) begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
    end
  end

  // Pattern table; a write in the load cycle lands after the read, so the old word is emitted
  always_ff @(posedge i_CLK) begin
    if (i_WR_EN) r_mem[i_WR_ADDR] <= i_WR_DATA;
  end

`ifdef PATTERN_ERR_INJ_EN
  // Sticky inject request, consumed by the next loaded word
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N)    r_inj <= 1'b0;
    else if (w_load) r_inj <= 1'b0;
    else             r_inj <= w_inj;
  end
`endif

  assign o_stream.o_DATA  = r_data;
  assign o_stream.o_VALID = r_valid;
  assign o_stream.o_SOF   = r_sof;

endmodule

// File: tb/tb_pattern_gen_param.sv
// Bench for pattern_gen_param: table-driven vectors, directed corner sequences,
// and a randomized run compared every cycle against a frame-level reference model.
module tb_pattern_gen_param;

  logic        clk = 1'b0;
  logic        rst_n, en, wr_en, inj;
  logic [1:0]  mode, wr_addr;
  logic [7:0]  len;
  logic [15:0] wr_data;

  int checks = 0;
  int failures = 0;

  pattern_gen_param_if #(.DW(16)) st_if ();

  pattern_gen_param #(.DW(16), .AW(2), .LW(8)) dut (
    .i_CLK     (clk),
    .i_RST_N   (rst_n),
    .i_EN      (en),
    .i_MODE    (mode),
    .i_LEN     (len),
    .i_WR_EN   (wr_en),
    .i_WR_ADDR (wr_addr),
    .i_WR_DATA (wr_data),
`ifdef PATTERN_ERR_INJ_EN
    .i_INJ     (inj),
`endif
    .o_stream  (st_if)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_tab [4];
  logic        prbs_bits [127];
  bit          m_run, m_inj, e_valid, e_sof;
  logic [15:0] e_data;
  logic [1:0]  m_mode;
  int          m_idx, m_len;

  function automatic logic [15:0] m_word(input logic [1:0] md, input int w);
    logic [15:0] r;
    r = '0;
    case (md)
      2'd0: r = m_tab[w % 4];
      2'd1: r = 16'(w);
      2'd2: r = 16'(1) << (w % 16);
      default: for (int b = 0; b < 16; b++) r[b] = prbs_bits[(w * 16 + b) % 127];
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    bit          ld;
    logic [15:0] wd;
    ld = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_inj = 0; e_valid = 0; e_sof = 0; e_data = '0; m_idx = 0;
    end else begin
      if (!m_run) begin
        if (en) begin
          m_run = 1; m_mode = mode; m_len = int'(len); m_idx = 0; e_sof = 1; ld = 1;
        end
      end else if (st_if.i_READY) begin
        if (en) begin
          if (m_idx == m_len) begin
            m_idx = 0; m_mode = mode; m_len = int'(len); e_sof = 1;
          end else begin
            m_idx++; e_sof = 0;
          end
          ld = 1;
        end else begin
          m_run = 0; e_valid = 0; e_sof = 0;
        end
      end
      if (ld) begin
        wd = m_word(m_mode, m_idx);
`ifdef PATTERN_ERR_INJ_EN
        if (m_inj || inj) wd[0] = ~wd[0];
        m_inj = 0;
`endif
        e_data = wd; e_valid = 1;
      end else begin
`ifdef PATTERN_ERR_INJ_EN
        m_inj = m_inj | inj;
`endif
      end
    end
    if (wr_en) m_tab[wr_addr] = wr_data;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_valid", 32'(st_if.o_VALID), 32'(e_valid));
    chk("model_sof", 32'(st_if.o_SOF), 32'(e_sof));
    if (e_valid) chk("model_data", 32'(st_if.o_DATA), 32'(e_data));
  endtask

  task automatic go_idle();
    en = 0; st_if.i_READY = 1; step(); step();
  endtask

  typedef struct {
    bit          en;
    bit          rdy;
    bit          ev;
    bit          es;
    logic [15:0] ed;
  } vec_t;

  vec_t        vt [11];
  logic [15:0] tab_init [4];
  logic [15:0] w0;
  logic [15:0] exp16;

  initial begin
    logic [6:0] s;
    s = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      prbs_bits[i] = s[6] ^ s[5];
      s = {s[5:0], prbs_bits[i]};
    end
    for (int i = 0; i < 4; i++) m_tab[i] = '0;
    m_mode = 0; m_len = 0;
    tab_init[0] = 16'hA6E2; tab_init[1] = 16'hF0A0;
    tab_init[2] = 16'h5CDB; tab_init[3] = 16'h475E;

    vt[0]  = '{1, 1, 1, 1, 16'hA6E2};
    vt[1]  = '{1, 1, 1, 0, 16'hF0A0};
    vt[2]  = '{1, 0, 1, 0, 16'hF0A0};
    vt[3]  = '{1, 0, 1, 0, 16'hF0A0};
    vt[4]  = '{1, 0, 1, 0, 16'hF0A0};
    vt[5]  = '{1, 1, 1, 0, 16'h5CDB};
    vt[6]  = '{1, 1, 1, 0, 16'h475E};
    vt[7]  = '{1, 1, 1, 1, 16'hA6E2};
    vt[8]  = '{0, 0, 1, 1, 16'hA6E2};
    vt[9]  = '{0, 1, 0, 0, 16'h0000};
    vt[10] = '{0, 1, 0, 0, 16'h0000};

    rst_n = 0; en = 0; mode = 0; len = 0; wr_en = 0; wr_addr = 0; wr_data = 0; inj = 0;
    st_if.i_READY = 1;
    step(); step();
    chk("reset_valid", 32'(st_if.o_VALID), 32'd0);
    chk("reset_sof", 32'(st_if.o_SOF), 32'd0);
    chk("reset_data", 32'(st_if.o_DATA), 32'd0);

    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_addr = 2'(i); wr_data = tab_init[i]; step();
    end
    wr_en = 0; step();

    // Table playback and backpressure
    mode = 2'd0; len = 8'd3;
    for (int i = 0; i < 11; i++) begin
      en = vt[i].en; st_if.i_READY = vt[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(st_if.o_VALID), 32'(vt[i].ev));
      chk($sformatf("vec%0d_sof", i), 32'(st_if.o_SOF), 32'(vt[i].es));
      if (vt[i].ev) chk($sformatf("vec%0d_data", i), 32'(st_if.o_DATA), 32'(vt[i].ed));
    end

    // Mode change mid-frame takes effect only at the next SOF
    en = 1; st_if.i_READY = 1; mode = 2'd0; len = 8'd3;
    step(); chk("mc_w0", 32'(st_if.o_DATA), 32'hA6E2);
    step(); chk("mc_w1", 32'(st_if.o_DATA), 32'hF0A0);
    mode = 2'd1;
    step(); chk("mc_w2", 32'(st_if.o_DATA), 32'h5CDB);
    step(); chk("mc_w3", 32'(st_if.o_DATA), 32'h475E);
    step(); chk("mc_cnt0", 32'(st_if.o_DATA), 32'h0000); chk("mc_cnt0_sof", 32'(st_if.o_SOF), 32'd1);
    step(); chk("mc_cnt1", 32'(st_if.o_DATA), 32'h0001);

    // Reset during a stall, then restart from index 0
    st_if.i_READY = 0; step();
    rst_n = 0; step();
    chk("rst_stall_valid", 32'(st_if.o_VALID), 32'd0);
    chk("rst_stall_data", 32'(st_if.o_DATA), 32'd0);
    rst_n = 1; st_if.i_READY = 1; en = 1; mode = 2'd1; len = 8'd5;
    step();
    chk("restart_sof", 32'(st_if.o_SOF), 32'd1);
    chk("restart_data", 32'(st_if.o_DATA), 32'd0);
    go_idle();

    // Counter, LEN=5
    mode = 2'd1; len = 8'd5; en = 1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("cnt_data", 32'(st_if.o_DATA), 32'(k % 6));
      chk("cnt_sof", 32'(st_if.o_SOF), 32'(k % 6 == 0));
    end
    go_idle();

    // Walking one, LEN=17
    mode = 2'd2; len = 8'd17; en = 1;
    for (int k = 0; k < 19; k++) begin
      step();
      exp16 = 16'd1 << ((k % 18) % 16);
      chk("walk_data", 32'(st_if.o_DATA), 32'(exp16));
      chk("walk_sof", 32'(st_if.o_SOF), 32'(k % 18 == 0));
    end
    go_idle();

    // PRBS7, LEN=254: period of 127 words, frame wraps at word 255
    mode = 2'd3; len = 8'd254; en = 1;
    w0 = '0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (k == 0) w0 = m_word(2'd3, 0);
      if (k == 0) chk("prbs_w0", 32'(st_if.o_DATA), 32'(w0));
      if (k == 127) begin
        chk("prbs_w127", 32'(st_if.o_DATA), 32'(w0));
        chk("prbs_w127_sof", 32'(st_if.o_SOF), 32'd0);
      end
      if (k == 255) begin
        chk("prbs_w255", 32'(st_if.o_DATA), 32'(w0));
        chk("prbs_w255_sof", 32'(st_if.o_SOF), 32'd1);
      end
    end
    go_idle();

`ifdef PATTERN_ERR_INJ_EN
    // Error injection in counter mode
    mode = 2'd1; len = 8'd9; en = 1;
    step(); step(); step();
    chk("inj_pre", 32'(st_if.o_DATA), 32'h0002);
    inj = 1; step(); inj = 0;
    chk("inj_hit", 32'(st_if.o_DATA), 32'h0002);
    step();
    chk("inj_clean", 32'(st_if.o_DATA), 32'h0004);
    go_idle();
`endif

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      st_if.i_READY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) len = 8'($urandom_range(0, 20));
      wr_en = ($urandom_range(0, 5) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 16'($urandom);
      rst_n = ($urandom_range(0, 150) != 0);
`ifdef PATTERN_ERR_INJ_EN
      inj = ($urandom_range(0, 20) == 0);
`endif
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
